// File: rtl/ukf_pkg.sv
// Shared constants, collector state encoding and pivot check for the UKF Cholesky path.
package ukf_pkg;

  localparam int DATA_W = 32;          // IEEE-754 single word
  localparam int N_MAX  = 8;           // largest supported matrix dimension
  localparam int IDX_W  = 3;           // row/column index width
  localparam int SIZE_W = IDX_W + 1;   // holds N in 1..N_MAX
  localparam int LANES  = 4;           // lower-column results per batch
  localparam int ADDR_W = 2 * IDX_W;   // {row, col} storage address

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DIAG = 2'd1,
    ST_LOWER     = 2'd2,
    ST_DONE      = 2'd3
  } coll_state_t;

  // A pivot is unusable when it is negative (sign bit, including -0.0)
  // or has zero magnitude.
  function automatic logic is_bad_pivot(input logic [DATA_W-1:0] word);
    return word[DATA_W-1] | (word[DATA_W-2:0] == '0);
  endfunction

endpackage

// File: rtl/chol_l_regfile.sv
// L-matrix storage: four lane write ports, one diagonal write port and one
// registered read port that masks the upper triangle and out-of-size cells.
module chol_l_regfile
  import ukf_pkg::*;
(
  input  logic                      clock,
  input  logic                      areset,
  input  logic [LANES-1:0]          i_lane_we,
  input  logic [LANES*IDX_W-1:0]    i_lane_row,
  input  logic [IDX_W-1:0]          i_lane_col,
  input  logic [LANES*DATA_W-1:0]   i_lane_wdata,
  input  logic                      i_diag_we,
  input  logic [IDX_W-1:0]          i_diag_idx,
  input  logic [DATA_W-1:0]         i_diag_wdata,
  input  logic                      i_rd_en,
  input  logic [IDX_W-1:0]          i_rd_row,
  input  logic [IDX_W-1:0]          i_rd_col,
  input  logic [SIZE_W-1:0]         i_size_n,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic                      o_rd_valid
);

  logic [DATA_W-1:0] r_mem [N_MAX*N_MAX];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic [ADDR_W-1:0] w_lane_addr [LANES];
  logic [DATA_W-1:0] w_lane_data [LANES];
  logic [ADDR_W-1:0] w_diag_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_rd_masked;

  // N_MAX is a power of two, so {row, col} is a dense row-major address.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_addr[gi] = {i_lane_row[gi*IDX_W +: IDX_W], i_lane_col};
      assign w_lane_data[gi] = i_lane_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_diag_addr = {i_diag_idx, i_diag_idx};
  assign w_rd_addr   = {i_rd_row, i_rd_col};

  // Upper triangle and anything outside the active N x N window read as zero.
  assign w_rd_masked = (i_rd_col > i_rd_row)
                    || ({1'b0, i_rd_row} >= i_size_n)
                    || ({1'b0, i_rd_col} >= i_size_n);

  // Storage writes; diagonal and lane writes never coincide and lane rows are distinct.
  always_ff @(posedge clock) begin
    if (i_diag_we) begin
      r_mem[w_diag_addr] <= i_diag_wdata;
    end
    for (int k = 0; k < LANES; k++) begin
      if (i_lane_we[k]) begin
        r_mem[w_lane_addr[k]] <= w_lane_data[k];
      end
    end
  end

  // Registered read; a same-cycle write is not visible until the next read.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        r_rd_data <= w_rd_masked ? '0 : r_mem[w_rd_addr];
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/chol_l_collector.sv
// Collects diagonal and lane results of the Cholesky datapath into the L
// matrix, tracks column progress and raises l_ready when the factor is complete.
module chol_l_collector
  import ukf_pkg::*;
(
  input  logic                 clock,
  input  logic                 areset,
  input  logic                 clear,
  input  logic                 start,
  input  logic [SIZE_W-1:0]    matrix_size,
  input  logic                 diag_valid,
  input  logic [DATA_W-1:0]    diag_data,
  input  logic [LANES-1:0]     lane_valid,
  input  logic [DATA_W-1:0]    lane_data0,
  input  logic [DATA_W-1:0]    lane_data1,
  input  logic [DATA_W-1:0]    lane_data2,
  input  logic [DATA_W-1:0]    lane_data3,
  input  logic                 rd_en,
  input  logic [IDX_W-1:0]     rd_row,
  input  logic [IDX_W-1:0]     rd_col,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 l_ready,
  output logic [IDX_W-1:0]     col_idx,
  output logic                 err_size,
  output logic                 err_stray,
  output logic                 err_not_pd
);

  coll_state_t         r_state;
  coll_state_t         w_state_next;
  logic [SIZE_W-1:0]   r_n;
  logic [IDX_W-1:0]    r_col;
  logic [SIZE_W-1:0]   r_base;
  logic                r_err_size;
  logic                r_err_stray;
  logic                r_err_not_pd;

  logic                w_start_cmd;
  logic                w_size_ok;
  logic                w_diag_acc;
  logic                w_batch;
  logic                w_last_batch;
  logic                w_last_col;
  logic                w_stray;
  logic [LANES-1:0]    w_lane_we;
  logic [LANES*IDX_W-1:0]  w_lane_row;
  logic [LANES*DATA_W-1:0] w_lane_wdata;
  logic [SIZE_W:0]     w_row_sum [LANES];

  // start is honoured only when no collection is running; clear overrides it.
  assign w_start_cmd  = start && !clear && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_size_ok    = (matrix_size != '0) && (matrix_size <= SIZE_W'(N_MAX));
  assign w_diag_acc   = !clear && (r_state == ST_WAIT_DIAG) && diag_valid;
  assign w_batch      = !clear && (r_state == ST_LOWER) && (|lane_valid);
  assign w_last_batch = ({1'b0, r_base} + (SIZE_W+1)'(LANES)) >= {1'b0, r_n};
  assign w_last_col   = ({1'b0, r_col} == (r_n - 1'b1));

  // Diagonals are only expected in WAIT_DIAG and lane batches only in LOWER.
  assign w_stray = !clear && (((r_state == ST_LOWER) && diag_valid)
                           || ((r_state != ST_LOWER) && (|lane_valid)));

  assign w_lane_wdata = {lane_data3, lane_data2, lane_data1, lane_data0};

  // Per-lane target row; lanes past the bottom of the matrix are masked off.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_row_sum[gi] = {1'b0, r_base} + (SIZE_W+1)'(gi);
      assign w_lane_we[gi] = w_batch && lane_valid[gi] && (w_row_sum[gi] < {1'b0, r_n});
      assign w_lane_row[gi*IDX_W +: IDX_W] = w_row_sum[gi][IDX_W-1:0];
    end
  endgenerate

  // State register.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; clear wins over every other event.
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_state_next = w_size_ok ? ST_WAIT_DIAG : ST_IDLE;
          end
        end
        ST_WAIT_DIAG: begin
          if (diag_valid) begin
            w_state_next = w_last_col ? ST_DONE : ST_LOWER;
          end
        end
        ST_LOWER: begin
          if (w_batch && w_last_batch) begin
            w_state_next = ST_WAIT_DIAG;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    busy    = 1'b0;
    l_ready = 1'b0;
    case (r_state)
      ST_WAIT_DIAG, ST_LOWER: busy    = 1'b1;
      ST_DONE:                l_ready = 1'b1;
      default: ;
    endcase
  end

  // Size, column and batch-base pointers.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      r_n    <= '0;
      r_col  <= '0;
      r_base <= '0;
    end else if (clear) begin
      r_col  <= '0;
      r_base <= '0;
    end else if (w_start_cmd) begin
      if (w_size_ok) begin
        r_n    <= matrix_size;
        r_col  <= '0;
        r_base <= SIZE_W'(1);
      end
    end else if (w_diag_acc) begin
      if (!w_last_col) begin
        r_base <= {1'b0, r_col} + 1'b1;
      end
    end else if (w_batch) begin
      r_base <= r_base + SIZE_W'(LANES);
      if (w_last_batch) begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Sticky error flags, cleared only by clear or areset.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      r_err_size   <= 1'b0;
      r_err_stray  <= 1'b0;
      r_err_not_pd <= 1'b0;
    end else if (clear) begin
      r_err_size   <= 1'b0;
      r_err_stray  <= 1'b0;
      r_err_not_pd <= 1'b0;
    end else begin
      if (w_start_cmd && !w_size_ok) begin
        r_err_size <= 1'b1;
      end
      if (w_stray) begin
        r_err_stray <= 1'b1;
      end
      if (w_diag_acc && is_bad_pivot(diag_data)) begin
        r_err_not_pd <= 1'b1;
      end
    end
  end

  assign col_idx    = r_col;
  assign err_size   = r_err_size;
  assign err_stray  = r_err_stray;
  assign err_not_pd = r_err_not_pd;

  chol_l_regfile u_regfile (
    .clock        (clock),
    .areset       (areset),
    .i_lane_we    (w_lane_we),
    .i_lane_row   (w_lane_row),
    .i_lane_col   (r_col),
    .i_lane_wdata (w_lane_wdata),
    .i_diag_we    (w_diag_acc),
    .i_diag_idx   (r_col),
    .i_diag_wdata (diag_data),
    .i_rd_en      (rd_en),
    .i_rd_row     (rd_row),
    .i_rd_col     (rd_col),
    .i_size_n     (r_n),
    .o_rd_data    (rd_data),
    .o_rd_valid   (rd_valid)
  );

endmodule

// File: tb/tb_chol_l_collector.sv
// Directed bench for chol_l_collector: full N=4 and N=8 runs, illegal sizes,
// stray/pivot flags, abort, and read/write collision.
module tb_chol_l_collector;

  logic        clock = 1'b0;
  logic        areset;
  logic        clear;
  logic        start;
  logic [3:0]  matrix_size;
  logic        diag_valid;
  logic [31:0] diag_data;
  logic [3:0]  lane_valid;
  logic [31:0] lane_d [4];
  logic        rd_en;
  logic [2:0]  rd_row;
  logic [2:0]  rd_col;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        l_ready;
  logic [2:0]  col_idx;
  logic        err_size;
  logic        err_stray;
  logic        err_not_pd;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          cur_n = 0;
  logic [31:0] exp_l [8][8];

  always #5 clock = ~clock;

  chol_l_collector dut (
    .clock       (clock),
    .areset      (areset),
    .clear       (clear),
    .start       (start),
    .matrix_size (matrix_size),
    .diag_valid  (diag_valid),
    .diag_data   (diag_data),
    .lane_valid  (lane_valid),
    .lane_data0  (lane_d[0]),
    .lane_data1  (lane_d[1]),
    .lane_data2  (lane_d[2]),
    .lane_data3  (lane_d[3]),
    .rd_en       (rd_en),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .l_ready     (l_ready),
    .col_idx     (col_idx),
    .err_size    (err_size),
    .err_stray   (err_stray),
    .err_not_pd  (err_not_pd)
  );

  function automatic logic [31:0] v(input logic [31:0] pfx, input int r, input int c);
    return pfx | 32'(r << 4) | 32'(c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    matrix_size = 4'(n);
    @(negedge clock);
    start = 1'b0;
    if (n >= 1 && n <= 8) cur_n = n;
    $display("start N=%0d", n);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    $display("clear");
  endtask

  task automatic do_diag(input int c, input logic [31:0] d);
    diag_valid = 1'b1;
    diag_data  = d;
    @(negedge clock);
    diag_valid = 1'b0;
    exp_l[c][c] = d;
    $display("diag col=%0d data=%h", c, d);
  endtask

  task automatic do_batch(input logic [3:0] mask, input int c, input int b, input logic [31:0] pfx);
    for (int k = 0; k < 4; k++) lane_d[k] = v(pfx, b + k, c);
    lane_valid = mask;
    @(negedge clock);
    lane_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (mask[k] && (b + k) < cur_n) exp_l[b + k][c] = v(pfx, b + k, c);
    end
    $display("batch col=%0d base=%0d mask=%b", c, b, mask);
  endtask

  task automatic rd_check(input int r, input int c, input logic [31:0] exp);
    rd_en  = 1'b1;
    rd_row = 3'(r);
    rd_col = 3'(c);
    @(negedge clock);
    rd_en = 1'b0;
    chk($sformatf("rdv_%0d_%0d", r, c), 32'(rd_valid), 32'd1);
    chk($sformatf("rd_%0d_%0d", r, c), rd_data, exp);
  endtask

  task automatic check_all();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (c <= r && r < cur_n) rd_check(r, c, exp_l[r][c]);
        else                     rd_check(r, c, 32'h0);
      end
    end
  endtask

  initial begin
    areset = 1'b1; clear = 1'b0; start = 1'b0; matrix_size = 4'd0;
    diag_valid = 1'b0; diag_data = 32'h0; lane_valid = 4'b0;
    for (int k = 0; k < 4; k++) lane_d[k] = 32'h0;
    rd_en = 1'b0; rd_row = 3'd0; rd_col = 3'd0;

    // Reset values
    repeat (3) @(negedge clock);
    areset = 1'b0;
    @(negedge clock);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_l_ready", 32'(l_ready), 32'd0);
    chk("rst_col_idx", 32'(col_idx), 32'd0);
    chk("rst_errs", {29'd0, err_size, err_stray, err_not_pd}, 32'd0);

    // N=4 full run
    do_start(4);
    chk("n4_busy", 32'(busy), 32'd1);
    do_diag(0, 32'h3F800000);
    do_batch(4'b1111, 0, 1, 32'h40000000);
    chk("n4_col1", 32'(col_idx), 32'd1);
    do_diag(1, v(32'h40000000, 1, 1));
    do_batch(4'b1111, 1, 2, 32'h40000000);
    do_diag(2, v(32'h40000000, 2, 2));
    do_batch(4'b1111, 2, 3, 32'h40000000);
    chk("n4_col3", 32'(col_idx), 32'd3);
    chk("n4_not_ready", 32'(l_ready), 32'd0);
    do_diag(3, v(32'h40000000, 3, 3));
    chk("n4_l_ready", 32'(l_ready), 32'd1);
    chk("n4_busy_done", 32'(busy), 32'd0);
    chk("n4_err_stray", 32'(err_stray), 32'd0);
    chk("n4_err_not_pd", 32'(err_not_pd), 32'd0);
    check_all();
    @(negedge clock);
    chk("rd_valid_drop", 32'(rd_valid), 32'd0);

    // N=8 full run with a read/write collision on L[2][1]
    do_start(8);
    for (int c = 0; c < 8; c++) begin
      do_diag(c, v(32'h41000000, c, c));
      for (int b = c + 1; b < 8; b += 4) begin
        if (c == 1 && b == 2) begin
          rd_en = 1'b1; rd_row = 3'd2; rd_col = 3'd1;
          do_batch(4'b1111, c, b, 32'h41000000);
          rd_en = 1'b0;
          chk("coll_v", 32'(rd_valid), 32'd1);
          chk("coll_old", rd_data, 32'h40000021);
          rd_check(2, 1, 32'h41000021);
        end else begin
          do_batch(4'b1111, c, b, 32'h41000000);
        end
        if (c == 0 && b == 1) chk("n8_col0_2nd", 32'(col_idx), 32'd0);
      end
    end
    chk("n8_l_ready", 32'(l_ready), 32'd1);
    chk("n8_col_idx", 32'(col_idx), 32'd7);
    chk("n8_err_stray", 32'(err_stray), 32'd0);
    check_all();

    // Illegal sizes
    do_clear();
    chk("clr_l_ready", 32'(l_ready), 32'd0);
    do_start(0);
    chk("sz0_err", 32'(err_size), 32'd1);
    chk("sz0_busy", 32'(busy), 32'd0);
    do_clear();
    chk("sz_clr", 32'(err_size), 32'd0);
    do_start(9);
    chk("sz9_err", 32'(err_size), 32'd1);
    chk("sz9_busy", 32'(busy), 32'd0);
    chk("sz9_l_ready", 32'(l_ready), 32'd0);
    do_clear();

    // Stray lane in WAIT_DIAG and a negative pivot, N=3
    do_start(3);
    lane_d[0] = 32'hDEADBEEF;
    lane_valid = 4'b0001;
    @(negedge clock);
    lane_valid = 4'b0000;
    chk("stray_err", 32'(err_stray), 32'd1);
    chk("stray_busy", 32'(busy), 32'd1);
    rd_check(1, 0, 32'h41000010);
    do_diag(0, 32'hBF800000);
    chk("npd_err", 32'(err_not_pd), 32'd1);
    chk("npd_busy", 32'(busy), 32'd1);
    do_batch(4'b1111, 0, 1, 32'h42000000);
    do_diag(1, v(32'h42000000, 1, 1));
    do_batch(4'b1111, 1, 2, 32'h42000000);
    do_diag(2, v(32'h42000000, 2, 2));
    chk("n3_l_ready", 32'(l_ready), 32'd1);
    rd_check(0, 0, 32'hBF800000);
    rd_check(2, 1, 32'h42000021);

    // Restart from DONE keeps flags; clear in LOWER aborts
    do_start(5);
    chk("rs_l_ready", 32'(l_ready), 32'd0);
    chk("rs_keep_stray", 32'(err_stray), 32'd1);
    chk("rs_keep_npd", 32'(err_not_pd), 32'd1);
    do_diag(0, v(32'h43000000, 0, 0));
    chk("ab_pre_busy", 32'(busy), 32'd1);
    do_clear();
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_l_ready", 32'(l_ready), 32'd0);
    chk("ab_col_idx", 32'(col_idx), 32'd0);
    chk("ab_errs", {29'd0, err_size, err_stray, err_not_pd}, 32'd0);

    // N=2 after the abort
    do_start(2);
    do_diag(0, v(32'h44000000, 0, 0));
    do_batch(4'b1111, 0, 1, 32'h44000000);
    chk("n2_col1", 32'(col_idx), 32'd1);
    do_diag(1, v(32'h44000000, 1, 1));
    chk("n2_l_ready", 32'(l_ready), 32'd1);
    chk("n2_errs", {29'd0, err_size, err_stray, err_not_pd}, 32'd0);
    rd_check(0, 0, 32'h44000000);
    rd_check(1, 0, 32'h44000010);
    rd_check(1, 1, 32'h44000011);
    rd_check(0, 1, 32'h0);
    rd_check(2, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
